// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the direct-mapped instruction cache.
// Imported by the cache top level and its word-select helper.
package icache_pkg;

  localparam int BLOCK_BITS      = 128;
  localparam int WORD_BITS       = 32;
  localparam int OFFSET_BITS     = 4;
  localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_BITS;
  localparam int BLOCK_ADDR_BITS = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_FETCH = 2'd1,
    UPDATE    = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_cache_if.sv
// CPU fetch port and block-memory read port of the instruction cache.
// The cache uses the slave modport; the CPU/memory side uses master.
interface instruction_cache_if;
  import icache_pkg::*;

  logic                       READ;
  logic [31:0]                ADDRESS;
  logic [WORD_BITS-1:0]       INSTRUCTION;
  logic                       BUSYWAIT;
  logic                       MEM_READ;
  logic [BLOCK_ADDR_BITS-1:0] MEM_BLOCK_ADDRESS;
  logic [BLOCK_BITS-1:0]      MEM_READ_INST;
  logic                       MEM_BUSYWAIT;

  modport master (
    output READ, ADDRESS, MEM_READ_INST, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_BLOCK_ADDRESS
  );

  modport slave (
    input  READ, ADDRESS, MEM_READ_INST, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_BLOCK_ADDRESS
  );

endinterface

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction out of a 128-bit cache block.
// Word n occupies block bits [32n+31:32n].
module icache_word_select
  import icache_pkg::*;
(
  input  logic [BLOCK_BITS-1:0] block_i,
  input  logic [1:0]            offset_i,
  output logic [WORD_BITS-1:0]  word_o
);

  always_comb begin
    word_o = block_i[WORD_BITS-1:0];
    case (offset_i)
      2'd0:    word_o = block_i[1*WORD_BITS-1:0*WORD_BITS];
      2'd1:    word_o = block_i[2*WORD_BITS-1:1*WORD_BITS];
      2'd2:    word_o = block_i[3*WORD_BITS-1:2*WORD_BITS];
      default: word_o = block_i[4*WORD_BITS-1:3*WORD_BITS];
    endcase
  end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, and a
// three-state miss FSM that fetches a whole block from instruction memory.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 28 - INDEX_BITS
) (
  input  logic                CLOCK,
  input  logic                RESET,
  instruction_cache_if.slave  bus
);

  localparam int SETS = 1 << INDEX_BITS;

  state_e                     state_q, state_d;
  logic                       fetch_seen_q, fetch_seen_d;
  logic [BLOCK_ADDR_BITS-1:0] blk_q, blk_d;
  logic [SETS-1:0]            valid_q;
  logic [WORD_BITS-1:0]       inst_q;

  logic [TAG_BITS-1:0]        tag_q  [SETS];
  logic [BLOCK_BITS-1:0]      data_q [SETS];

  logic [INDEX_BITS-1:0]      req_idx;
  logic [TAG_BITS-1:0]        req_tag;
  logic [INDEX_BITS-1:0]      fill_idx;
  logic [TAG_BITS-1:0]        fill_tag;
  logic                       hit;
  logic [WORD_BITS-1:0]       hit_word;

  logic                       busy;
  logic                       mem_read;
  logic                       serve;
  logic                       fill_en;
  logic                       unused_addr_bits;

  assign req_idx  = bus.ADDRESS[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign req_tag  = bus.ADDRESS[31:OFFSET_BITS+INDEX_BITS];
  assign fill_idx = blk_q[INDEX_BITS-1:0];
  assign fill_tag = blk_q[BLOCK_ADDR_BITS-1:INDEX_BITS];

  assign unused_addr_bits = ^bus.ADDRESS[1:0];

  assign hit = bus.READ && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  icache_word_select u_word_select (
    .block_i  (data_q[req_idx]),
    .offset_i (bus.ADDRESS[3:2]),
    .word_o   (hit_word)
  );

  always_comb begin
    state_d      = state_q;
    fetch_seen_d = fetch_seen_q;
    blk_d        = blk_q;
    busy         = 1'b0;
    mem_read     = 1'b0;
    serve        = 1'b0;
    fill_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.READ && !hit) begin
          busy         = 1'b1;
          state_d      = MEM_FETCH;
          blk_d        = bus.ADDRESS[31:OFFSET_BITS];
          fetch_seen_d = 1'b0;
        end else begin
          serve = hit;
        end
      end
      MEM_FETCH: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        // Memory only raises MEM_BUSYWAIT after seeing MEM_READ, so the first
        // edge in this state must not treat a low MEM_BUSYWAIT as "done".
        if (!fetch_seen_q) begin
          fetch_seen_d = 1'b1;
        end else if (!bus.MEM_BUSYWAIT) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        busy    = 1'b1;
        fill_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.BUSYWAIT          = busy && !RESET;
  assign bus.MEM_READ          = mem_read;
  assign bus.MEM_BLOCK_ADDRESS = blk_q;
  assign bus.INSTRUCTION       = serve ? hit_word : inst_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      fetch_seen_q <= 1'b0;
      blk_q        <= '0;
      valid_q      <= '0;
      inst_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_seen_q <= fetch_seen_d;
      blk_q        <= blk_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
      if (serve)   inst_q <= hit_word;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge CLOCK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.MEM_READ_INST;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache with a behavioural
// memory responder and a set/block-number reference model of cache contents.
module tb_instruction_cache;
  import icache_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET;
  always #5 CLOCK = ~CLOCK;

  instruction_cache_if bus();

  instruction_cache #(.INDEX_BITS(3)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  int          mem_lat;
  logic        model_valid [8];
  logic [27:0] model_blk   [8];
  logic [31:0] last_inst;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    logic [127:0] blk;
    for (int k = 0; k < 4; k++) blk[32*k +: 32] = mem[{b[5:0], 2'(k)}];
    return blk;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 8; s++) begin
      model_valid[s] = 1'b0;
      model_blk[s]   = '0;
    end
    last_inst = '0;
  endfunction

  // Memory: raise busy on MEM_READ, return the block mem_lat edges later.
  initial begin
    logic [27:0] ba;
    bus.MEM_BUSYWAIT  = 1'b0;
    bus.MEM_READ_INST = '0;
    forever begin
      @(posedge CLOCK); #1;
      if (bus.MEM_READ && !RESET) begin
        bus.MEM_BUSYWAIT = 1'b1;
        ba = bus.MEM_BLOCK_ADDRESS;
        for (int k = 0; k < mem_lat; k++) begin
          @(posedge CLOCK); #1;
          if (RESET) break;
        end
        bus.MEM_READ_INST = mem_block(ba);
        bus.MEM_BUSYWAIT  = 1'b0;
        @(posedge CLOCK); #1;
      end
    end
  end

  // Called just after a posedge; returns just after a posedge.
  task automatic do_fetch(input logic [31:0] addr);
    logic [27:0] b;
    int          idx;
    logic        exp_hit;
    logic [31:0] exp_w;
    int          cyc;
    b       = addr[31:4];
    idx     = int'(b[2:0]);
    exp_hit = model_valid[idx] && (model_blk[idx] == b);
    exp_w   = mem[addr[9:2]];
    bus.READ    = 1'b1;
    bus.ADDRESS = addr;
    @(negedge CLOCK);
    if (exp_hit) begin
      check("hit_busywait", 64'(bus.BUSYWAIT), 64'd0);
      check("hit_instruction", 64'(bus.INSTRUCTION), 64'(exp_w));
      check("hit_mem_read", 64'(bus.MEM_READ), 64'd0);
    end else begin
      check("miss_busywait", 64'(bus.BUSYWAIT), 64'd1);
      @(negedge CLOCK);
      check("miss_mem_read", 64'(bus.MEM_READ), 64'd1);
      check("miss_block_addr", 64'(bus.MEM_BLOCK_ADDRESS), 64'(b));
      cyc = 1;
      while (bus.BUSYWAIT && cyc < 300) begin
        @(negedge CLOCK);
        cyc++;
      end
      check("miss_penalty", 64'(cyc), 64'(mem_lat + 3));
      check("fill_instruction", 64'(bus.INSTRUCTION), 64'(exp_w));
      model_valid[idx] = 1'b1;
      model_blk[idx]   = b;
    end
    last_inst = exp_w;
    @(posedge CLOCK); #1;
  endtask

  task automatic idle_gap(input logic [31:0] addr);
    bus.READ    = 1'b0;
    bus.ADDRESS = addr;
    @(negedge CLOCK);
    check("idle_hold_instruction", 64'(bus.INSTRUCTION), 64'(last_inst));
    check("idle_busywait", 64'(bus.BUSYWAIT), 64'd0);
    @(posedge CLOCK); #1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] prev;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8F108093;
    mem[3] = 32'h0000F613;
    mem[6] = 32'h001600A3;
    mem[9] = 32'hF2360103;
    model_clear();
    mem_lat     = 40;
    RESET       = 1'b1;
    bus.READ    = 1'b1;
    bus.ADDRESS = '0;
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    check("reset_busywait", 64'(bus.BUSYWAIT), 64'd0);
    check("reset_mem_read", 64'(bus.MEM_READ), 64'd0);
    check("reset_instruction", 64'(bus.INSTRUCTION), 64'd0);
    bus.READ = 1'b0;
    @(posedge CLOCK); #1;
    RESET = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      check("idle_busywait_cold", 64'(bus.BUSYWAIT), 64'd0);
      check("idle_mem_read_cold", 64'(bus.MEM_READ), 64'd0);
    end
    @(posedge CLOCK); #1;

    do_fetch(32'h0000_0000);
    do_fetch(32'h0000_000C);
    mem_lat = 3;
    do_fetch(32'h0000_0018);
    do_fetch(32'h0000_0024);
    do_fetch(32'h0000_0080);
    do_fetch(32'h0000_0000);
    for (int i = 0; i < 3; i++) idle_gap(32'h0000_0018 + 32'(4 * i));

    // Reset while a fill is in flight.
    mem_lat     = 10;
    bus.READ    = 1'b1;
    bus.ADDRESS = 32'h0000_0040;
    repeat (4) @(negedge CLOCK);
    check("prereset_mem_read", 64'(bus.MEM_READ), 64'd1);
    #2 RESET = 1'b1;
    #1;
    check("midfill_reset_mem_read", 64'(bus.MEM_READ), 64'd0);
    check("midfill_reset_busywait", 64'(bus.BUSYWAIT), 64'd0);
    check("midfill_reset_instruction", 64'(bus.INSTRUCTION), 64'd0);
    model_clear();
    bus.READ = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1 RESET = 1'b0;
    mem_lat = 2;
    do_fetch(32'h0000_000C);

    prev = 32'h0000_000C;
    for (int i = 0; i < 80; i++) begin
      mem_lat = int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) addr = {prev[31:4], 4'h0} | (32'($urandom_range(0, 3)) << 2);
      else addr = 32'($urandom_range(0, 255)) << 2;
      do_fetch(addr);
      prev = addr;
      if ($urandom_range(0, 3) == 0) idle_gap(32'($urandom_range(0, 255)) << 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
